fetcher: RTL and testbench

FETCHER -- requirements
Module: fetcher

---
 rtl/fetcher.sv | 139 +++++++++++++
 tb/tb_fetcher.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Instruction fetcher: keeps one memory read in flight, buffers returned words
// in an 8-entry circular queue, and dispatches them in fetch order whenever all
// downstream units report a free slot. A ROB misbranch flushes the queue and
// redirects fetch; a response that was already in flight is dropped.
module fetcher (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,

  output logic        out_mem_ce,
  output logic [31:0] out_mem_pc,
  input  logic        in_mem_ce,
  input  logic [31:0] in_mem_inst,

  input  logic        in_rs_idle,
  input  logic        in_lsb_idle,
  input  logic        in_rob_idle,

  output logic        out_ce,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,

  input  logic        in_rob_misbranch,
  input  logic [31:0] in_rob_newpc
);

  localparam int unsigned DEPTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,   // free to issue a request
    S_WAIT,   // request outstanding, response will be queued
    S_DROP    // request outstanding, response is stale and discarded
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [2:0]  head;
  logic [2:0]  tail;
  logic [3:0]  count;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];

  logic do_push;
  logic do_pop;
  logic do_req;

  // Per-cycle queue/request decisions; misbranch and a stalled pipeline veto all of them.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_req  = 1'b0;
    if (rdy && !in_rob_misbranch) begin
      do_push = (state == S_WAIT) && in_mem_ce;
      do_pop  = (count != 4'd0) && in_rs_idle && in_lsb_idle && in_rob_idle;
      do_req  = (state == S_IDLE) && (count != 4'd8);
    end
  end

  // Queue storage: written at the tail when a live response is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; head/tail/count decide which slots are valid, so stale contents are never read.
    if (!rst && do_push) begin
      inst_q[tail] <= in_mem_inst;
      pc_q[tail]   <= fetch_pc;
    end
  end

  // Control FSM, pointers, fetch PC and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      state      <= S_IDLE;
      fetch_pc   <= 32'd0;
      head       <= 3'd0;
      tail       <= 3'd0;
      count      <= 4'd0;
      out_ce     <= 1'b0;
      out_inst   <= 32'd0;
      out_pc     <= 32'd0;
      out_mem_ce <= 1'b0;
      out_mem_pc <= 32'd0;
    end else if (!rdy) begin
      // Frozen: strobes are forced low, everything else holds.
      out_ce     <= 1'b0;
      out_mem_ce <= 1'b0;
    end else if (in_rob_misbranch) begin
      // Flush and redirect; an in-flight request must still be absorbed.
      head       <= 3'd0;
      tail       <= 3'd0;
      count      <= 4'd0;
      fetch_pc   <= in_rob_newpc;
      out_ce     <= 1'b0;
      out_mem_ce <= 1'b0;
      case (state)
        S_WAIT, S_DROP: state <= in_mem_ce ? S_IDLE : S_DROP;
        default:        state <= S_IDLE;
      endcase
    end else begin
      out_mem_ce <= do_req;
      out_ce     <= do_pop;

      case (state)
        S_IDLE: begin
          if (do_req) begin
            out_mem_pc <= fetch_pc;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_mem_ce) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_IDLE;
          end
        end
        S_DROP: begin
          if (in_mem_ce) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (do_pop) begin
        out_inst <= inst_q[head];
        out_pc   <= pc_q[head];
        head     <= head + 3'd1;
      end

      if (do_push) tail <= tail + 3'd1;

      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: a two-cycle-latency memory model answers every
// request, a monitor records requests and dispatches, and one task per
// scenario checks the recorded sequences against hand-computed values.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        out_mem_ce;
  logic [31:0] out_mem_pc;
  logic        in_mem_ce;
  logic [31:0] in_mem_inst;
  logic        in_rs_idle;
  logic        in_lsb_idle;
  logic        in_rob_idle;
  logic        out_ce;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        in_rob_misbranch;
  logic [31:0] in_rob_newpc;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [31:0] req_q[$];
  logic [31:0] disp_pc_q[$];
  logic [31:0] disp_inst_q[$];
  int          disp_cyc_q[$];

  bit          mem_tag = 1'b1;
  int          pending = 0;
  logic [31:0] pend_pc = 32'd0;

  fetcher dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .out_mem_ce       (out_mem_ce),
    .out_mem_pc       (out_mem_pc),
    .in_mem_ce        (in_mem_ce),
    .in_mem_inst      (in_mem_inst),
    .in_rs_idle       (in_rs_idle),
    .in_lsb_idle      (in_lsb_idle),
    .in_rob_idle      (in_rob_idle),
    .out_ce           (out_ce),
    .out_inst         (out_inst),
    .out_pc           (out_pc),
    .in_rob_misbranch (in_rob_misbranch),
    .in_rob_newpc     (in_rob_newpc)
  );

  always #5 clk = ~clk;

  // Word the memory returns for an address: plain addi nop, or tagged with the pc.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_tag ? {pc[23:0], 8'h13} : 32'h0000_0013;
    return w;
  endfunction

  // Memory model: a request seen in cycle c is answered with a one-cycle pulse in cycle c+2.
  initial begin
    in_mem_ce   = 1'b0;
    in_mem_inst = 32'd0;
    forever begin
      @(negedge clk);
      in_mem_ce = 1'b0;
      if (pending > 0) begin
        pending = pending - 1;
        if (pending == 0) begin
          in_mem_ce   = 1'b1;
          in_mem_inst = mem_word(pend_pc);
        end
      end
      if (out_mem_ce === 1'b1) begin
        pending = 2;
        pend_pc = out_mem_pc;
      end
    end
  end

  // Monitor: records every request and dispatch with its cycle stamp.
  initial begin
    forever begin
      @(negedge clk);
      cycle = cycle + 1;
      if (out_mem_ce === 1'b1) req_q.push_back(out_mem_pc);
      if (out_ce === 1'b1) begin
        disp_pc_q.push_back(out_pc);
        disp_inst_q.push_back(out_inst);
        disp_cyc_q.push_back(cycle);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] req_at(input int i);
    if (i < req_q.size()) return req_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dpc_at(input int i);
    if (i < disp_pc_q.size()) return disp_pc_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dinst_at(input int i);
    if (i < disp_inst_q.size()) return disp_inst_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_q.delete();
    disp_pc_q.delete();
    disp_inst_q.delete();
    disp_cyc_q.delete();
  endtask

  task automatic do_reset(input logic rs_idle);
    rst              = 1'b1;
    rdy              = 1'b1;
    in_rob_misbranch = 1'b0;
    in_rob_newpc     = 32'd0;
    in_rs_idle       = rs_idle;
    in_lsb_idle      = 1'b1;
    in_rob_idle      = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_reqs(input int n, input string name);
    int k = 0;
    while (req_q.size() < n && k < 400) begin
      step();
      k++;
    end
    if (req_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: requests seen %0d, required at least %0d", name, req_q.size(), n);
    end
  endtask

  task automatic wait_disps(input int n, input string name);
    int k = 0;
    while (disp_pc_q.size() < n && k < 400) begin
      step();
      k++;
    end
    if (disp_pc_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: dispatches seen %0d, required at least %0d", name, disp_pc_q.size(), n);
    end
  endtask

  // Reset clears all outputs and wins over rdy=0 and a misbranch.
  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; in_rob_misbranch = 1'b1; in_rob_newpc = 32'h40;
    in_rs_idle = 1'b1; in_lsb_idle = 1'b1; in_rob_idle = 1'b1;
    repeat (3) step();
    checks++; if (out_ce !== 1'b0) begin errors++; $display("FAIL reset_out_ce: got %b want 0", out_ce); end
    checks++; if (out_mem_ce !== 1'b0) begin errors++; $display("FAIL reset_out_mem_ce: got %b want 0", out_mem_ce); end
    checks++; if (out_mem_pc !== 32'd0) begin errors++; $display("FAIL reset_out_mem_pc: got %h want 0", out_mem_pc); end
    checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    rst = 1'b0; rdy = 1'b1; in_rob_misbranch = 1'b0;
    clear_logs();
    wait_reqs(1, "reset_first_req");
    checks++; if (req_at(0) !== 32'd0) begin errors++; $display("FAIL reset_first_pc: got %h want 0", req_at(0)); end
  endtask

  // Plain streaming with fixed nop responses.
  task automatic test_stream();
    mem_tag = 1'b0;
    do_reset(1'b1);
    wait_disps(3, "stream");
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_at(i) !== 32'(i * 4)) begin errors++; $display("FAIL stream_req%0d: got %h want %h", i, req_at(i), 32'(i * 4)); end
      checks++; if (dpc_at(i) !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc%0d: got %h want %h", i, dpc_at(i), 32'(i * 4)); end
      checks++; if (dinst_at(i) !== 32'h13) begin errors++; $display("FAIL stream_inst%0d: got %h want 00000013", i, dinst_at(i)); end
    end
    mem_tag = 1'b1;
  endtask

  // Fill all 8 slots while blocked, then drain back-to-back across the pointer wrap.
  task automatic test_fill_wrap();
    do_reset(1'b0);
    repeat (60) step();
    checks++; if (req_q.size() != 8) begin errors++; $display("FAIL fill_req_count: got %0d want 8", req_q.size()); end
    checks++; if (disp_pc_q.size() != 0) begin errors++; $display("FAIL fill_no_disp: got %0d want 0", disp_pc_q.size()); end
    in_rs_idle = 1'b1; in_lsb_idle = 1'b0;
    repeat (3) step();
    checks++; if (disp_pc_q.size() != 0) begin errors++; $display("FAIL lsb_block: got %0d dispatches want 0", disp_pc_q.size()); end
    in_lsb_idle = 1'b1; in_rob_idle = 1'b0;
    repeat (3) step();
    checks++; if (disp_pc_q.size() != 0) begin errors++; $display("FAIL rob_block: got %0d dispatches want 0", disp_pc_q.size()); end
    in_rob_idle = 1'b1;
    wait_disps(9, "drain");
    for (int i = 0; i < 8; i++) begin
      checks++; if (dpc_at(i) !== 32'(i * 4)) begin errors++; $display("FAIL drain_pc%0d: got %h want %h", i, dpc_at(i), 32'(i * 4)); end
    end
    if (disp_cyc_q.size() >= 8) begin
      checks++;
      if (disp_cyc_q[7] - disp_cyc_q[0] != 7) begin
        errors++; $display("FAIL drain_b2b: span %0d cycles want 7", disp_cyc_q[7] - disp_cyc_q[0]);
      end
    end
    checks++; if (req_at(8) !== 32'h20) begin errors++; $display("FAIL resume_req: got %h want 00000020", req_at(8)); end
    checks++; if (dpc_at(8) !== 32'h20) begin errors++; $display("FAIL wrap_pc: got %h want 00000020", dpc_at(8)); end
    checks++; if (dinst_at(8) !== 32'h0000_2013) begin errors++; $display("FAIL wrap_inst: got %h want 00002013", dinst_at(8)); end
  endtask

  // Misbranch while waiting; the response lands one cycle later and is dropped.
  task automatic test_misbranch_wait();
    do_reset(1'b1);
    wait_reqs(1, "mb_wait_req");
    step();
    in_rob_misbranch = 1'b1; in_rob_newpc = 32'h100;
    step();
    in_rob_misbranch = 1'b0;
    wait_disps(1, "mb_wait_disp");
    checks++; if (req_at(1) !== 32'h100) begin errors++; $display("FAIL mb_wait_req: got %h want 00000100", req_at(1)); end
    checks++; if (dpc_at(0) !== 32'h100) begin errors++; $display("FAIL mb_wait_pc: got %h want 00000100", dpc_at(0)); end
    checks++; if (dinst_at(0) !== 32'h0001_0013) begin errors++; $display("FAIL mb_wait_inst: got %h want 00010013", dinst_at(0)); end
  endtask

  // Misbranch in the same cycle as the response, with entries already queued.
  task automatic test_misbranch_coincident();
    do_reset(1'b0);
    wait_reqs(3, "mb_co_req");
    step();
    step();
    in_rob_misbranch = 1'b1; in_rob_newpc = 32'h200; in_rs_idle = 1'b1;
    step();
    in_rob_misbranch = 1'b0;
    checks++; if (out_ce !== 1'b0) begin errors++; $display("FAIL mb_co_out_ce: got %b want 0", out_ce); end
    checks++; if (out_mem_ce !== 1'b0) begin errors++; $display("FAIL mb_co_mem_ce: got %b want 0", out_mem_ce); end
    wait_disps(1, "mb_co_disp");
    checks++; if (req_at(3) !== 32'h200) begin errors++; $display("FAIL mb_co_req: got %h want 00000200", req_at(3)); end
    checks++; if (dpc_at(0) !== 32'h200) begin errors++; $display("FAIL mb_co_pc: got %h want 00000200", dpc_at(0)); end
    checks++; if (dinst_at(0) !== 32'h0002_0013) begin errors++; $display("FAIL mb_co_inst: got %h want 00020013", dinst_at(0)); end
  endtask

  // rdy low for 5 cycles right after a push: nothing moves, then the stream resumes unchanged.
  task automatic test_rdy_stall();
    int k = 0;
    do_reset(1'b1);
    wait_reqs(3, "stall_req");
    while (in_mem_ce !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    checks++; if (in_mem_ce !== 1'b1) begin errors++; $display("FAIL stall_resp: got %b want 1", in_mem_ce); end
    step();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_ce !== 1'b0 || out_mem_ce !== 1'b0) begin
        errors++; $display("FAIL stall_quiet%0d: out_ce=%b out_mem_ce=%b want 0 0", i, out_ce, out_mem_ce);
      end
    end
    rdy = 1'b1;
    wait_disps(5, "stall_disp");
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_at(i) !== 32'(i * 4)) begin errors++; $display("FAIL stall_req%0d: got %h want %h", i, req_at(i), 32'(i * 4)); end
      checks++; if (dpc_at(i) !== 32'(i * 4)) begin errors++; $display("FAIL stall_pc%0d: got %h want %h", i, dpc_at(i), 32'(i * 4)); end
    end
  endtask

  // Reset with 3 entries queued and a request outstanding; the late response is ignored.
  task automatic test_reset_in_wait();
    do_reset(1'b1);
    wait_disps(2, "rw_pre");
    in_rs_idle = 1'b0;
    wait_reqs(6, "rw_req");
    step();
    rst = 1'b1; in_rs_idle = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_ce !== 1'b0) begin errors++; $display("FAIL rw_out_ce: got %b want 0", out_ce); end
    checks++; if (out_mem_ce !== 1'b0) begin errors++; $display("FAIL rw_mem_ce: got %b want 0", out_mem_ce); end
    checks++; if (out_mem_pc !== 32'd0) begin errors++; $display("FAIL rw_mem_pc: got %h want 0", out_mem_pc); end
    checks++; if (out_inst !== 32'd0) begin errors++; $display("FAIL rw_out_inst: got %h want 0", out_inst); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rw_out_pc: got %h want 0", out_pc); end
    clear_logs();
    wait_disps(1, "rw_disp");
    checks++; if (req_at(0) !== 32'd0) begin errors++; $display("FAIL rw_next_req: got %h want 0", req_at(0)); end
    checks++; if (dpc_at(0) !== 32'd0) begin errors++; $display("FAIL rw_first_pc: got %h want 0", dpc_at(0)); end
    checks++; if (dinst_at(0) !== 32'h13) begin errors++; $display("FAIL rw_first_inst: got %h want 00000013", dinst_at(0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_wrap();
    test_misbranch_wait();
    test_misbranch_coincident();
    test_rdy_stall();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
